// File: rtl/textlcd_buf_ctrl.sv
// HD44780-style text LCD controller: runs the power-on init sequence, then streams a
// ROWS x COLS character buffer to the panel one byte per timing slot, refreshing dirty rows.
module textlcd_buf_ctrl #(
  parameter int unsigned COLS         = 16,
  parameter int unsigned ROWS         = 2,
  parameter int unsigned CLK_PER_CMD  = 2000,
  parameter int unsigned EN_RISE      = 200,
  parameter int unsigned EN_FALL      = 1800,
  parameter int unsigned CLR_SLOTS    = 2,
  parameter logic [6:0]  ROW1_ADDR    = 7'h40,
  parameter int unsigned REFRESH_MODE = 0
) (
  input  logic                                                  lcdclk,
  input  logic                                                  reset,
  input  logic                                                  wr_en,
  input  logic [((ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1)-1:0]  wr_addr,
  input  logic [7:0]                                            wr_char,
  output logic                                                  init_done,
  output logic                                                  busy,
  output logic                                                  lcd_rs,
  output logic                                                  lcd_rw,
  output logic                                                  lcd_en,
  output logic [7:0]                                            lcd_data
);
  localparam int unsigned NCHR = ROWS * COLS;
  localparam int unsigned AW   = (NCHR > 1) ? $clog2(NCHR) : 1;
  localparam int unsigned IMAX = (COLS > CLR_SLOTS) ? ((COLS > 6) ? COLS : 6)
                                                    : ((CLR_SLOTS > 6) ? CLR_SLOTS : 6);
  localparam int unsigned IW   = $clog2(IMAX);
  localparam int unsigned CW   = (CLK_PER_CMD > 1) ? $clog2(CLK_PER_CMD) : 1;

  typedef enum logic [2:0] {S_INIT, S_CLRW, S_IDLE, S_SETA, S_WRITE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            row_q, row_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [ROWS-1:0] dirty_q, dirty_d;
  logic [7:0]      chr_q [NCHR];
  logic [7:0]      chr_d [NCHR];
  logic            init_done_q, init_done_d;
  logic            busy_q, busy_d;
  logic            en_q, en_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;

  logic            slot_end, pick_valid, pick_row, do_pick, wr_ok, wr_row, active;
  logic [AW-1:0]   rd_idx;

  function automatic logic [7:0] init_cmd(input logic [IW-1:0] step);
    case (32'(step))
      0, 1:    return 8'h38;
      2:       return 8'h0E;
      3:       return 8'h06;
      4:       return 8'h02;
      default: return 8'h01;
    endcase
  endfunction

  assign active = (state_q == S_INIT) || (state_q == S_SETA) || (state_q == S_WRITE);

  always_ff @(posedge lcdclk) begin
    if (reset) begin
      state_q     <= S_INIT;
      idx_q       <= '0;
      row_q       <= 1'b0;
      cnt_q       <= '0;
      dirty_q     <= '1;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h38;
      for (int unsigned i = 0; i < NCHR; i++) chr_q[i] <= 8'h20;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      dirty_q     <= dirty_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      en_q        <= en_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      chr_q       <= chr_d;
    end
  end

  always_comb begin
    slot_end = (cnt_q == CW'(CLK_PER_CMD - 1));
    cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
    if (REFRESH_MODE != 0) begin
      pick_valid = 1'b1;
      pick_row   = (ROWS == 2) && (state_q == S_WRITE) && !row_q;
    end else begin
      pick_valid = |dirty_q;
      pick_row   = (ROWS == 2) && !dirty_q[0];
    end
    state_d     = state_q;
    idx_d       = idx_q;
    row_d       = row_q;
    dirty_d     = dirty_q;
    init_done_d = init_done_q;
    do_pick     = 1'b0;
    if (slot_end) begin
      unique case (state_q)
        S_INIT: begin
          if (idx_q == IW'(5)) begin
            if (CLR_SLOTS == 0) begin
              init_done_d = 1'b1;
              do_pick     = 1'b1;
            end else begin
              state_d = S_CLRW;
              idx_d   = '0;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        S_CLRW: begin
          if (idx_q == IW'(CLR_SLOTS - 1)) begin
            init_done_d = 1'b1;
            do_pick     = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        S_IDLE: do_pick = 1'b1;
        S_SETA: begin
          state_d = S_WRITE;
          idx_d   = '0;
        end
        S_WRITE: begin
          if (idx_q == IW'(COLS - 1)) do_pick = 1'b1;
          else                        idx_d   = idx_q + IW'(1);
        end
        default: state_d = S_INIT;
      endcase
      if (do_pick) begin
        idx_d = '0;
        if (pick_valid) begin
          state_d           = S_SETA;
          row_d             = pick_row;
          dirty_d[pick_row] = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
    end
    // Applied after the SETA clear so a write on the same edge keeps the row dirty.
    wr_ok  = wr_en && (32'(wr_addr) < NCHR);
    wr_row = (ROWS == 2) && (32'(wr_addr) >= COLS);
    chr_d  = chr_q;
    if (wr_ok) begin
      chr_d[wr_addr]  = wr_char;
      dirty_d[wr_row] = 1'b1;
    end
  end

  always_comb begin
    rd_idx = AW'(32'(row_d) * COLS + 32'(idx_d));
    rs_d   = rs_q;
    data_d = data_q;
    if (slot_end) begin
      unique case (state_d)
        S_INIT: begin
          rs_d   = 1'b0;
          data_d = init_cmd(idx_d);
        end
        S_SETA: begin
          rs_d   = 1'b0;
          data_d = {1'b1, row_d ? ROW1_ADDR : 7'h00};
        end
        // Reads the pre-write buffer; a colliding write is caught by the dirty bit.
        S_WRITE: begin
          rs_d   = 1'b1;
          data_d = chr_q[rd_idx];
        end
        default: begin
          rs_d   = 1'b0;
          data_d = 8'h00;
        end
      endcase
    end
    en_d = en_q;
    if ((cnt_q == CW'(EN_RISE)) && active) en_d = 1'b1;
    if (cnt_q == CW'(EN_FALL))             en_d = 1'b0;
    busy_d = (state_d != S_IDLE);
  end

  assign init_done = init_done_q;
  assign busy      = busy_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_en    = en_q;
  assign lcd_data  = data_q;

endmodule
